wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 6 +
 rtl/wb_arbiter_mux.sv | 11 +
 rtl/wb_arbiter.sv | 65 ++++++
 3 files changed

// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared write-back widths and output-register state encoding
package wb_arbiter_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
endpackage

// File: rtl/wb_arbiter_mux.sv
// mux_32Bit: 2:1 word mux, b selected when sel is high
module mux_32Bit #(
  parameter int W = 32
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin two-requester write-back arbiter with one-entry output register
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter bit DROP_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  input  logic              wr_stall,
  output logic              gnt0,
  output logic              gnt1,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);
  state_t state;
  logic last;
  logic accept, win1, gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  always_comb begin
    accept = !reset && (state == EMPTY || !wr_stall);
    win1   = req1 && (!req0 || !last);
    gnt0   = accept && req0 && !win1;
    gnt1   = accept && win1;
    gnt    = gnt0 || gnt1;
  end
  // winner choice depends on the registered last-winner pointer
  mux_32Bit #(.W(ADDR_W + DATA_W)) u_mux (
    .sel(win1),
    .a  ({addr0, data0}),
    .b  ({addr1, data1}),
    .y  ({sel_addr, sel_data})
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= EMPTY;
      last    <= 1'b1;
      busy    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (gnt) begin
      state   <= FULL;
      busy    <= 1'b1;
      last    <= gnt1;
      wr_addr <= sel_addr;
      wr_data <= sel_data;
      wr_en   <= !(DROP_R0 && sel_addr == '0);
    end else if (state == FULL && !wr_stall) begin
      state <= EMPTY;
      busy  <= 1'b0;
      wr_en <= 1'b0;
    end
  end
endmodule
